// File: rtl/t21_io_ctrl.sv
// TIS-style blocking I/O controller: one read and/or write per request across four
// neighbour ports, with ANY/LAST/NIL addressing.
module t21_io_ctrl #(
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        rd_dir,
    input  logic [2:0]        wr_dir,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] left_in_data,
    input  logic              left_in_ready,
    output logic              left_in_ack,
    output logic [DATA_W-1:0] left_out_data,
    output logic              left_out_ready,
    input  logic              left_out_ack,
    input  logic [DATA_W-1:0] right_in_data,
    input  logic              right_in_ready,
    output logic              right_in_ack,
    output logic [DATA_W-1:0] right_out_data,
    output logic              right_out_ready,
    input  logic              right_out_ack,
    input  logic [DATA_W-1:0] up_in_data,
    input  logic              up_in_ready,
    output logic              up_in_ack,
    output logic [DATA_W-1:0] up_out_data,
    output logic              up_out_ready,
    input  logic              up_out_ack,
    input  logic [DATA_W-1:0] down_in_data,
    input  logic              down_in_ready,
    output logic              down_in_ack,
    output logic [DATA_W-1:0] down_out_data,
    output logic              down_out_ready,
    input  logic              down_out_ack
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [2:0] DIR_ANY  = 3'd4;
    localparam logic [2:0] DIR_LAST = 3'd5;
    localparam logic [2:0] DIR_NIL  = 3'd6;

    state_t              state_q, state_d;
    logic [2:0]          rd_dir_q, rd_dir_d, wr_dir_q, wr_dir_d, last_q, last_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   value_q, value_d, rd_data_q, rd_data_d;

    logic [3:0]              in_ready_vec, out_ack_vec, rd_mask, wr_mask, rd_win, wr_win;
    logic [3:0]              in_ack_vec, out_ready_vec;
    logic [3:0][DATA_W-1:0]  in_data_vec;
    logic [DATA_W-1:0]       sel_data;

    // Port bit order is LEFT..DOWN = 0..3, which is also the priority order.
    function automatic logic [3:0] dir_mask(input logic [2:0] dir, input logic [2:0] last);
        logic [3:0] m;
        m = 4'b0000;
        case (dir)
            3'd0, 3'd1, 3'd2, 3'd3: m = 4'b0001 << dir[1:0];
            DIR_ANY:                m = 4'b1111;
            DIR_LAST:               m = last[2] ? 4'b0000 : (4'b0001 << last[1:0]);
            default:                m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] win_idx(input logic [3:0] oh);
        logic [2:0] idx;
        idx = DIR_NIL;
        for (int i = 3; i >= 0; i--) if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

    assign in_ready_vec = {down_in_ready, up_in_ready, right_in_ready, left_in_ready};
    assign out_ack_vec  = {down_out_ack, up_out_ack, right_out_ack, left_out_ack};
    assign in_data_vec  = {down_in_data, up_in_data, right_in_data, left_in_data};

    always_comb begin
        rd_mask       = dir_mask(rd_dir_q, last_q);
        wr_mask       = dir_mask(wr_dir_q, last_q);
        rd_win        = (rd_mask & in_ready_vec) & (~(rd_mask & in_ready_vec) + 4'd1);
        wr_win        = (wr_mask & out_ack_vec) & (~(wr_mask & out_ack_vec) + 4'd1);
        in_ack_vec    = (state_q == READ)  ? rd_win  : 4'b0000;
        out_ready_vec = (state_q == WRITE) ? wr_mask : 4'b0000;
        sel_data      = '0;
        for (int i = 0; i < 4; i++) if (rd_win[i]) sel_data = in_data_vec[i];

        state_d   = state_q;
        rd_dir_d  = rd_dir_q;
        wr_dir_d  = wr_dir_q;
        wr_en_d   = wr_en_q;
        last_d    = last_q;
        value_d   = value_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: if (req) begin
                rd_dir_d = rd_dir;
                wr_dir_d = wr_dir;
                wr_en_d  = wr_en;
                value_d  = wr_data;
                state_d  = rd_en ? READ : (wr_en ? WRITE : DONE);
            end
            READ: if (rd_mask == 4'b0000 || rd_win != 4'b0000) begin
                // A NIL read yields 0 without touching any port.
                value_d   = sel_data;
                rd_data_d = sel_data;
                if (rd_dir_q == DIR_ANY) last_d = win_idx(rd_win);
                state_d   = wr_en_q ? WRITE : DONE;
            end
            WRITE: if (wr_mask == 4'b0000 || wr_win != 4'b0000) begin
                if (wr_dir_q == DIR_ANY) last_d = win_idx(wr_win);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_dir_q  <= DIR_NIL;
            wr_dir_q  <= DIR_NIL;
            wr_en_q   <= 1'b0;
            last_q    <= DIR_NIL;
            value_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_dir_q  <= rd_dir_d;
            wr_dir_q  <= wr_dir_d;
            wr_en_q   <= wr_en_d;
            last_q    <= last_d;
            value_q   <= value_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign rd_data = rd_data_q;

    assign {down_in_ack, up_in_ack, right_in_ack, left_in_ack}         = in_ack_vec;
    assign {down_out_ready, up_out_ready, right_out_ready, left_out_ready} = out_ready_vec;
    assign left_out_data  = value_q;
    assign right_out_data = value_q;
    assign up_out_data    = value_q;
    assign down_out_data  = value_q;
endmodule

// File: tb/tb_t21_io_ctrl.sv
// Scenario bench for t21_io_ctrl; expected read values queue up at request time
// and are compared when done pulses.
module tb_t21_io_ctrl;
    localparam int W = 11;
    localparam logic [2:0] L = 3'd0, R = 3'd1, U = 3'd2, D = 3'd3;
    localparam logic [2:0] ANY = 3'd4, LAST = 3'd5, NIL = 3'd6;

    logic clk = 0, reset = 1;
    logic req = 0, rd_en = 0, wr_en = 0;
    logic [2:0] rd_dir = 0, wr_dir = 0;
    logic [W-1:0] wr_data = 0;
    logic busy, done;
    logic [W-1:0] rd_data;
    logic [W-1:0] l_id = 0, r_id = 0, u_id = 0, d_id = 0;
    logic l_ir = 0, r_ir = 0, u_ir = 0, d_ir = 0;
    logic l_oa = 0, r_oa = 0, u_oa = 0, d_oa = 0;
    logic l_ia, r_ia, u_ia, d_ia, l_or, r_or, u_or, d_or;
    logic [W-1:0] l_od, r_od, u_od, d_od;

    int checks = 0, failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;

    t21_io_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .rd_en(rd_en), .wr_en(wr_en),
        .rd_dir(rd_dir), .wr_dir(wr_dir), .wr_data(wr_data),
        .busy(busy), .done(done), .rd_data(rd_data),
        .left_in_data(l_id), .left_in_ready(l_ir), .left_in_ack(l_ia),
        .left_out_data(l_od), .left_out_ready(l_or), .left_out_ack(l_oa),
        .right_in_data(r_id), .right_in_ready(r_ir), .right_in_ack(r_ia),
        .right_out_data(r_od), .right_out_ready(r_or), .right_out_ack(r_oa),
        .up_in_data(u_id), .up_in_ready(u_ir), .up_in_ack(u_ia),
        .up_out_data(u_od), .up_out_ready(u_or), .up_out_ack(u_oa),
        .down_in_data(d_id), .down_in_ready(d_ir), .down_in_ack(d_ia),
        .down_out_data(d_od), .down_out_ready(d_or), .down_out_ack(d_oa)
    );

    always #5 clk = ~clk;

    wire [3:0] acks = {d_ia, u_ia, r_ia, l_ia};
    wire [3:0] offs = {d_or, u_or, r_or, l_or};

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Request sits across one rising edge; returns at the negedge of cycle 1.
    task automatic issue(input logic re, input logic we, input logic [2:0] rdir,
                         input logic [2:0] wdir, input logic [W-1:0] wd);
        req = 1; rd_en = re; wr_en = we; rd_dir = rdir; wr_dir = wdir; wr_data = wd;
        tick;
        req = 0;
    endtask

    task automatic clear_ports;
        {l_ir, r_ir, u_ir, d_ir} = 4'b0;
        {l_oa, r_oa, u_oa, d_oa} = 4'b0;
    endtask

    task automatic test_reset;
        reset = 1;
        #1;
        checks++;
        if ({busy, done, acks, offs} !== 10'b0) begin
            failures++; $display("FAIL reset_ctl got=%b want=0", {busy, done, acks, offs});
        end
        checks++;
        if ({rd_data, l_od, r_od, u_od, d_od} !== '0) begin
            failures++; $display("FAIL reset_data rd_data=%0d l_od=%0d", rd_data, l_od);
        end
        tick;
        reset = 0;
        tick;
    endtask

    task automatic test_blocking_read;
        issue(1, 0, L, NIL, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1 || acks !== 4'b0) begin
                failures++; $display("FAIL block_wait cyc=%0d busy=%b acks=%b want 1/0000", i, busy, acks);
            end
            tick;
        end
        l_ir = 1; l_id = 11'(-42); exp_q.push_back(11'(-42));
        #1;
        checks++;
        if (acks !== 4'b0001 || done !== 0) begin
            failures++; $display("FAIL block_ack acks=%b done=%b want 0001/0", acks, done);
        end
        tick;
        l_ir = 0;
        #1;
        checks++;
        if (acks !== 4'b0 || done !== 1 || busy !== 1) begin
            failures++; $display("FAIL block_done acks=%b done=%b busy=%b want 0000/1/1", acks, done, busy);
        end
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin
            failures++; $display("FAIL block_data got=%0d want=%0d", $signed(rd_data), $signed(e));
        end
        tick;
        checks++;
        if (done !== 0 || busy !== 0) begin
            failures++; $display("FAIL block_idle done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_any_priority;
        u_ir = 1; u_id = 7; d_ir = 1; d_id = 9; exp_q.push_back(7);
        issue(1, 0, ANY, NIL, 0);
        checks++;
        if (acks !== 4'b0100) begin
            failures++; $display("FAIL any_ack got=%b want=0100", acks);
        end
        tick;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1 || rd_data !== e) begin
            failures++; $display("FAIL any_done done=%b rd=%0d want 1/%0d", done, rd_data, e);
        end
        tick;
        u_id = 33; d_id = 44; exp_q.push_back(33);
        issue(1, 0, LAST, NIL, 0);
        checks++;
        if (acks !== 4'b0100) begin
            failures++; $display("FAIL last_ack got=%b want=0100", acks);
        end
        tick;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1 || rd_data !== e) begin
            failures++; $display("FAIL last_done done=%b rd=%0d want 1/%0d", done, rd_data, e);
        end
        clear_ports;
        tick;
    endtask

    task automatic test_write_any;
        issue(0, 1, NIL, ANY, 999);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (offs !== 4'b1111 || {l_od, r_od, u_od, d_od} !== {4{11'd999}} || done !== 0) begin
                failures++; $display("FAIL wany_offer cyc=%0d offs=%b l_od=%0d d_od=%0d want 1111/999", i, offs, l_od, d_od);
            end
            if (i == 0) tick;
        end
        r_oa = 1; d_oa = 1;
        tick;
        clear_ports;
        #1;
        checks++;
        if (offs !== 4'b0 || done !== 1) begin
            failures++; $display("FAIL wany_done offs=%b done=%b want 0000/1", offs, done);
        end
        tick;
        // LAST must now be RIGHT even with LEFT also ready.
        l_ir = 1; l_id = 66; r_ir = 1; r_id = 77; exp_q.push_back(77);
        issue(1, 0, LAST, NIL, 0);
        checks++;
        if (acks !== 4'b0010) begin
            failures++; $display("FAIL wany_last got=%b want=0010", acks);
        end
        tick;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin
            failures++; $display("FAIL wany_last_data got=%0d want=%0d", rd_data, e);
        end
        clear_ports;
        tick;
    endtask

    task automatic test_mov;
        u_ir = 1; u_id = 5; exp_q.push_back(5);
        issue(1, 1, U, D, 0);
        checks++;
        if (acks !== 4'b0100 || offs !== 4'b0) begin
            failures++; $display("FAIL mov_read acks=%b offs=%b want 0100/0000", acks, offs);
        end
        tick;
        u_ir = 0; r_oa = 1;
        #1;
        checks++;
        if (offs !== 4'b1000 || d_od !== 11'd5 || done !== 0) begin
            failures++; $display("FAIL mov_offer offs=%b d_od=%0d done=%b want 1000/5/0", offs, d_od, done);
        end
        tick;
        checks++;
        if (offs !== 4'b1000 || done !== 0) begin
            failures++; $display("FAIL mov_ignore offs=%b done=%b want 1000/0", offs, done);
        end
        r_oa = 0; d_oa = 1;
        tick;
        d_oa = 0;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1 || rd_data !== e || offs !== 4'b0) begin
            failures++; $display("FAIL mov_done done=%b rd=%0d offs=%b want 1/%0d/0000", done, rd_data, offs, e);
        end
        tick;
    endtask

    task automatic test_nil_last;
        l_ir = 1; l_id = 12; exp_q.push_back(0);
        issue(1, 0, NIL, NIL, 0);
        checks++;
        if (acks !== 4'b0) begin
            failures++; $display("FAIL nil_ack got=%b want=0000", acks);
        end
        tick;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1 || rd_data !== e) begin
            failures++; $display("FAIL nil_done done=%b rd=%0d want 1/%0d", done, rd_data, e);
        end
        tick;
        reset = 1; tick; reset = 0; tick;
        {l_ir, r_ir, u_ir, d_ir} = 4'b1111; exp_q.push_back(0);
        issue(1, 0, LAST, NIL, 0);
        checks++;
        if (acks !== 4'b0) begin
            failures++; $display("FAIL lastnil_ack got=%b want=0000", acks);
        end
        tick;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1 || rd_data !== e) begin
            failures++; $display("FAIL lastnil_done done=%b rd=%0d want 1/%0d", done, rd_data, e);
        end
        clear_ports;
        tick;
        issue(0, 1, NIL, NIL, 123);
        checks++;
        if (offs !== 4'b0 || busy !== 1) begin
            failures++; $display("FAIL wnil_offer offs=%b busy=%b want 0000/1", offs, busy);
        end
        tick;
        checks++;
        if (done !== 1) begin
            failures++; $display("FAIL wnil_done got=%b want=1", done);
        end
        tick;
    endtask

    task automatic test_reset_in_write;
        int seen;
        issue(0, 1, NIL, L, 321);
        checks++;
        if (offs !== 4'b0001) begin
            failures++; $display("FAIL rstw_offer got=%b want=0001", offs);
        end
        reset = 1;
        #1;
        checks++;
        if (offs !== 4'b0 || busy !== 0 || l_od !== 0) begin
            failures++; $display("FAIL rstw_drop offs=%b busy=%b l_od=%0d want 0000/0/0", offs, busy, l_od);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) reset = 0;
            tick;
            if (done) seen++;
        end
        checks++;
        if (seen !== 0 || busy !== 0) begin
            failures++; $display("FAIL rstw_nodone pulses=%0d busy=%b want 0/0", seen, busy);
        end
        r_ir = 1; r_id = 55; exp_q.push_back(55);
        issue(1, 0, R, NIL, 0);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1 || rd_data !== e) begin
            failures++; $display("FAIL rstw_new done=%b rd=%0d want 1/%0d", done, rd_data, e);
        end
        clear_ports;
        tick;
    endtask

    task automatic test_back_to_back;
        int n;
        issue(1, 0, D, NIL, 0);
        req = 1; rd_en = 0; wr_en = 1; wr_dir = L;
        tick; tick;
        req = 0;
        checks++;
        if (busy !== 1 || acks !== 4'b0 || offs !== 4'b0) begin
            failures++; $display("FAIL b2b_ignore busy=%b acks=%b offs=%b want 1/0000/0000", busy, acks, offs);
        end
        d_ir = 1; d_id = 11'(-1); exp_q.push_back(11'(-1));
        n = 0;
        while (!done && n < 20) begin tick; n++; end
        d_ir = 0;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1 || rd_data !== e) begin
            failures++; $display("FAIL b2b_done done=%b rd=%0d after %0d cycles want 1/%0d", done, rd_data, n, e);
        end
        tick;
        l_ir = 1; l_id = 200; u_oa = 1; exp_q.push_back(200);
        issue(1, 1, L, ANY, 0);
        checks++;
        if (acks !== 4'b0001) begin
            failures++; $display("FAIL rw_read got=%b want=0001", acks);
        end
        tick;
        checks++;
        if (offs !== 4'b1111 || u_od !== 11'd200 || done !== 0) begin
            failures++; $display("FAIL rw_write offs=%b u_od=%0d done=%b want 1111/200/0", offs, u_od, done);
        end
        tick;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1 || rd_data !== e) begin
            failures++; $display("FAIL rw_done done=%b rd=%0d want 1/%0d (cycle 3)", done, rd_data, e);
        end
        clear_ports;
        tick;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_blocking_read;
        test_any_priority;
        test_write_any;
        test_mov;
        test_nil_last;
        test_reset_in_write;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/t21_io_ctrl.md
T21_IO_CTRL -- requirements
Module: t21_io_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 11, port data width (signed TIS value).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 1, start an I/O operation; sampled only in IDLE.
REQ-005 SHALL have ports rd_en/wr_en, input, 1 each, operation includes a read and/or a write.
REQ-006 SHALL have ports rd_dir/wr_dir, input, 3 each, with encoding 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN, 4 ANY, 5 LAST, 6/7 NIL.
REQ-007 SHALL have port wr_data, input, DATA_W, write value when rd_en=0.
REQ-008 SHALL have ports busy/done, output, 1 each, stall to PC and one-cycle completion pulse.
REQ-009 SHALL have port rd_data, output, DATA_W, registered value of the last read.
REQ-010 SHALL have, per d in {left,right,up,down}, ports d_in_data (in, DATA_W), d_in_ready (in, 1), d_in_ack (out, 1), d_out_data (out, DATA_W), d_out_ready (out, 1), d_out_ack (in, 1).

Function
REQ-011 SHALL implement states IDLE, READ, WRITE and DONE; busy=1 in every state except IDLE.
REQ-012 SHALL, in IDLE with req=1, latch rd_dir, wr_dir and wr_data, then go to READ if rd_en=1, else WRITE if wr_en=1, else DONE.
REQ-013 SHALL ignore req outside IDLE.
REQ-014 SHALL, in READ, compute the candidate set from the latched rd_dir: one port; all four for ANY; the stored LAST port for LAST.
REQ-015 SHALL, in READ, when a candidate has in_ready=1, assert that port's in_ack combinationally in the same cycle and capture its in_data into the value register.
REQ-016 SHALL resolve ANY by fixed priority LEFT > RIGHT > UP > DOWN, with at most one in_ack high in any cycle.
REQ-017 SHALL, in READ with no candidate ready, hold the READ state indefinitely with all in_ack low.
REQ-018 SHALL, on a NIL read (including LAST while LAST=NIL), capture 0 with no ack, taking one READ cycle.
REQ-019 SHALL, after a read completes, go to WRITE if wr_en=1 (the write value is the read value), else to DONE.
REQ-020 SHALL, in WRITE, drive out_data=value on all four ports and out_ready=1 only on candidate ports (same candidate rules as the read side, using wr_dir).
REQ-021 SHALL, on out_ack from an offered port, go to DONE with all out_ready low from the next cycle.
REQ-022 SHALL resolve simultaneous out_acks by the REQ-016 priority.
REQ-023 SHALL ignore out_ack on ports that are not offered.
REQ-024 SHALL complete a NIL write in one WRITE cycle with no out_ready.
REQ-025 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE.
REQ-026 SHALL update rd_data on read capture.
REQ-027 SHALL update LAST only on an ANY read or write, setting it to the winning port; an operation using LAST SHALL not modify it.
REQ-028 SHALL meet these latencies, with req in cycle 0 and data or ack already present: read done in cycle 2; write done in cycle 2; read+write done in cycle 3.

Reset
REQ-029 SHALL, while reset=1, asynchronously force state IDLE, LAST=NIL, rd_data=0, the value register=0, busy=0, done=0, and every in_ack, out_ready and out_data to 0.
REQ-030 SHALL, on reset mid-operation, abandon the transaction with no done pulse; offers SHALL drop immediately and no ack SHALL be issued.

Verification
REQ-031 SHALL verify a blocking read: req rd_dir=LEFT with left_in_ready low for 5 cycles, then high with data -42 -> left_in_ack for exactly one cycle, done 1 cycle later, rd_data=-42, busy high throughout.
REQ-032 SHALL verify ANY priority: rd_dir=ANY with up and down both ready (7, 9) -> up_in_ack only, rd_data=7. A following rd_dir=LAST with down ready and up ready -> up_in_ack, rd_data=up data.
REQ-033 SHALL verify a write to ANY: wr_data=999 -> all four out_ready=1 with out_data=999. right_out_ack and down_out_ack together -> RIGHT wins, all out_ready low next cycle, done, LAST=RIGHT.
REQ-034 SHALL verify a forwarding MOV: rd_en and wr_en, rd_dir=UP (data 5), wr_dir=DOWN -> up_in_ack, then down_out_ready with 5 until down_out_ack, then done. rd_data=5.
REQ-035 SHALL verify NIL and LAST after reset: a read with rd_dir=NIL -> done in cycle 2 with rd_data=0. After reset, rd_dir=LAST -> 0 with no ack. A write to NIL -> done in cycle 2 with no out_ready.
REQ-036 SHALL verify reset in WRITE: offer on LEFT, then reset asserted -> left_out_ready low in the same cycle, no done pulse, IDLE after release, and a new req accepted.
